// File: rtl/qam_mod_core_if.sv
// Port bundle for qam_mod_core: bit-source handshake, NCO tuning word and the
// symbol/carrier/passband outputs. The core attaches through the slave modport.
interface qam_mod_core_if #(
  parameter int BITS_PER_SYM = 4,
  parameter int PHASE_W      = 16,
  parameter int AMP_W        = 10
);
  localparam int K = BITS_PER_SYM / 2;

  logic                       en;
  logic                       src_sel;
  logic                       ext_bit;
  logic                       ext_valid;
  logic                       ext_ready;
  logic [PHASE_W-1:0]         fcw;
  logic signed [K:0]          sym_i;
  logic signed [K:0]          sym_q;
  logic                       sym_strobe;
  logic signed [AMP_W-1:0]    sin_out;
  logic signed [AMP_W-1:0]    cos_out;
  logic signed [AMP_W+K+1:0]  mod_out;
  logic                       mod_valid;
  logic                       underrun;

  modport master (
    output en, src_sel, ext_bit, ext_valid, fcw,
    input  ext_ready, sym_i, sym_q, sym_strobe, sin_out, cos_out,
           mod_out, mod_valid, underrun
  );

  modport slave (
    input  en, src_sel, ext_bit, ext_valid, fcw,
    output ext_ready, sym_i, sym_q, sym_strobe, sin_out, cos_out,
           mod_out, mod_valid, underrun
  );
endinterface

// File: rtl/qam_mod_core.sv
// M-QAM modulator: serial bits (PRBS or external) packed into Gray-mapped I/Q
// levels, mixed onto an NCO carrier as I*cos - Q*sin. Single clock, en-gated.
module qam_mod_core #(
  parameter int BITS_PER_SYM = 4,
  parameter int BIT_DIV      = 4,
  parameter int PHASE_W      = 16,
  parameter int LUT_AW       = 8,
  parameter int AMP_W        = 10
) (
  input logic           clk,
  input logic           rst,
  qam_mod_core_if.slave bus
);
  localparam int  K     = BITS_PER_SYM / 2;
  localparam int  DIV_W = $clog2(BIT_DIV);
  localparam int  CNT_W = $clog2(BITS_PER_SYM);
  localparam int  MOD_W = AMP_W + K + 2;
  localparam int  LVL_W = K + 2;
  localparam int  LUT_N = 2 ** LUT_AW;
  localparam int  PEAK  = 2 ** (AMP_W - 1) - 1;
  localparam real PI    = 3.14159265358979323846;

  function automatic logic signed [AMP_W-1:0] sin_entry(input int a);
    real x;
    x = real'(PEAK) * $sin(2.0 * PI * real'(a) / real'(LUT_N));
    if (x >= 0.0) return AMP_W'($rtoi(x + 0.5));
    else          return AMP_W'(-$rtoi(0.5 - x));
  endfunction

  function automatic logic signed [K:0] gray_level(input logic [K-1:0] g);
    logic [K-1:0]   b;
    logic [K+1:0]   t;
    b[K-1] = g[K-1];
    for (int i = K - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    t = {1'b0, b, 1'b0} - LVL_W'(2 ** K - 1);
    return t[K:0];
  endfunction

  logic [DIV_W-1:0]        r_div;
  logic [CNT_W-1:0]        r_bcnt;
  logic [6:0]              r_lfsr;
  logic [BITS_PER_SYM-1:0] r_shift;
  logic                    r_load;
  logic                    r_underrun;
  logic                    r_strobe;
  logic                    r_sym_ok;
  logic                    r_mod_ok;
  logic signed [K:0]       r_sym_i;
  logic signed [K:0]       r_sym_q;
  logic [PHASE_W-1:0]      r_phase;
  logic signed [AMP_W-1:0] r_sin;
  logic signed [AMP_W-1:0] r_cos;
  logic signed [MOD_W-1:0] r_mod;

  logic                    w_tick;
  logic                    w_last;
  logic                    w_bit;
  logic [BITS_PER_SYM-1:0] w_word;
  logic [LUT_AW-1:0]       w_addr;
  logic [LUT_AW-1:0]       w_addr_c;
  logic signed [MOD_W-1:0] w_mi, w_mq, w_mc, w_ms, w_mix;
  logic signed [AMP_W-1:0] w_lut [LUT_N];

  for (genvar g = 0; g < LUT_N; g++) begin : g_lut
    assign w_lut[g] = sin_entry(g);
  end

  assign w_tick   = bus.en & (r_div == DIV_W'(BIT_DIV - 1));
  assign w_last   = (r_bcnt == CNT_W'(BITS_PER_SYM - 1));
  assign w_word   = {r_shift[BITS_PER_SYM-2:0], w_bit};
  assign w_addr   = r_phase[PHASE_W-1 -: LUT_AW];
  assign w_addr_c = w_addr + LUT_AW'(LUT_N / 4);
  assign w_mi     = MOD_W'(r_sym_i);
  assign w_mq     = MOD_W'(r_sym_q);
  assign w_mc     = MOD_W'(r_cos);
  assign w_ms     = MOD_W'(r_sin);
  assign w_mix    = w_mi * w_mc - w_mq * w_ms;

  // Serial bit source; a missing external bit is replaced by zero.
  always_comb begin
    w_bit = 1'b0;
    if (bus.src_sel) begin
      if (bus.ext_valid) w_bit = bus.ext_bit;
      else               w_bit = 1'b0;
    end else begin
      w_bit = r_lfsr[6];
    end
  end

  // Bit divider, PRBS, symbol packing and underrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div      <= '0;
      r_bcnt     <= '0;
      r_lfsr     <= 7'b0000001;
      r_shift    <= '0;
      r_load     <= 1'b0;
      r_underrun <= 1'b0;
    end else if (bus.en) begin
      r_div  <= w_tick ? '0 : r_div + DIV_W'(1);
      r_load <= w_tick & w_last;
      if (w_tick) begin
        r_shift <= w_word;
        r_bcnt  <= w_last ? '0 : r_bcnt + CNT_W'(1);
        if (!bus.src_sel) r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
        if (bus.src_sel && !bus.ext_valid) r_underrun <= 1'b1;
      end
    end
  end

  // Symbol mapping, NCO and mixer; r_shift stays stable for at least one en
  // cycle after the last bit, so it doubles as the symbol register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sym_i  <= '0;
      r_sym_q  <= '0;
      r_strobe <= 1'b0;
      r_sym_ok <= 1'b0;
      r_mod_ok <= 1'b0;
      r_phase  <= '0;
      r_sin    <= '0;
      r_cos    <= '0;
      r_mod    <= '0;
    end else if (bus.en) begin
      if (r_load) begin
        r_sym_i <= gray_level(r_shift[BITS_PER_SYM-1 -: K]);
        r_sym_q <= gray_level(r_shift[K-1:0]);
      end
      r_strobe <= r_load;
      r_sym_ok <= r_sym_ok | r_load;
      r_mod_ok <= r_sym_ok;
      r_phase  <= r_phase + bus.fcw;
      r_sin    <= w_lut[w_addr];
      r_cos    <= w_lut[w_addr_c];
      r_mod    <= w_mix;
    end else begin
      r_strobe <= 1'b0;
    end
  end

  assign bus.ext_ready  = w_tick & bus.src_sel;
  assign bus.sym_i      = r_sym_i;
  assign bus.sym_q      = r_sym_q;
  assign bus.sym_strobe = r_strobe;
  assign bus.sin_out    = r_sin;
  assign bus.cos_out    = r_cos;
  assign bus.mod_out    = r_mod;
  assign bus.mod_valid  = bus.en & r_mod_ok;
  assign bus.underrun   = r_underrun;
endmodule

// File: tb/tb_qam_mod_core.sv
// Directed bench for qam_mod_core (16-QAM defaults): expected symbols are queued
// from the bit stream driven and compared whenever sym_strobe fires.
module tb_qam_mod_core;
  localparam int  BPS     = 4;
  localparam int  BIT_DIV = 4;
  localparam int  PHASE_W = 16;
  localparam int  LUT_AW  = 8;
  localparam int  AMP_W   = 10;
  localparam real PI      = 3.14159265358979323846;

  typedef struct { int i; int q; } sym_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   n;
  sym_t exp_q[$];
  sym_t last_sym;
  sym_t s1;
  logic [6:0]  m_lfsr;
  logic [15:0] ready_mask;
  int   sin_tab[4];
  int   cos_tab[4];

  qam_mod_core_if #(.BITS_PER_SYM(BPS), .PHASE_W(PHASE_W), .AMP_W(AMP_W)) bus ();

  qam_mod_core #(
    .BITS_PER_SYM(BPS), .BIT_DIV(BIT_DIV), .PHASE_W(PHASE_W),
    .LUT_AW(LUT_AW), .AMP_W(AMP_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int lvl(input logic [1:0] g);
    case (g)
      2'b00:   return -3;
      2'b01:   return -1;
      2'b11:   return 1;
      default: return 3;
    endcase
  endfunction

  task automatic push_word(input logic [3:0] w);
    sym_t s;
    s.i = lvl(w[3:2]);
    s.q = lvl(w[1:0]);
    exp_q.push_back(s);
    last_sym = s;
  endtask

  task automatic push_prbs();
    logic [3:0] w;
    w = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      w      = {w[2:0], m_lfsr[6]};
      m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
    end
    push_word(w);
  endtask

  function automatic int rnd_sin(input int a);
    real x;
    x = 511.0 * $sin(2.0 * PI * real'(a % 256) / 256.0);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(0.5 - x);
  endfunction

  function automatic int sinm(input int ph);
    return rnd_sin((ph % 65536) / 256);
  endfunction

  function automatic int cosm(input int ph);
    return rnd_sin((ph % 65536) / 256 + 64);
  endfunction

  // One clock; outputs sampled 1 time unit after the edge, strobes scored.
  task automatic step();
    sym_t e;
    @(posedge clk);
    #1;
    if (bus.sym_strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", bus.sym_strobe, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sym_i", bus.sym_i, e.i);
        chk("sym_q", bus.sym_q, e.q);
      end
    end
  endtask

  task automatic wait_strobe(input int bound, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (bus.sym_strobe !== 1'b1 && cnt < bound);
    if (bus.sym_strobe !== 1'b1) chk("strobe_timeout", bus.sym_strobe, 1);
  endtask

  task automatic send_bit(input logic b, input logic v);
    int k;
    bus.ext_bit   = b;
    bus.ext_valid = v;
    #1;
    k = 0;
    while (bus.ext_ready !== 1'b1 && k < 2 * BIT_DIV) begin
      step();
      k++;
    end
    if (bus.ext_ready !== 1'b1) chk("ext_ready_timeout", bus.ext_ready, 1);
    step();
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    bus.en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      bus.src_sel   = j[0];
      bus.ext_bit   = 1'($urandom_range(0, 1));
      bus.ext_valid = j[1];
      bus.fcw       = 16'($urandom);
      step();
    end
    chk("reset_outputs", {bus.sym_i, bus.sym_q, bus.sym_strobe, bus.sin_out, bus.cos_out,
                          bus.mod_out, bus.mod_valid, bus.underrun, bus.ext_ready}, 0);
    bus.en        = 1'b0;
    bus.src_sel   = 1'b0;
    bus.ext_valid = 1'b0;
    bus.ext_bit   = 1'b0;
    bus.fcw       = '0;
    #1 rst = 1'b1;
    exp_q.delete();
    m_lfsr = 7'b0000001;
  endtask

  initial begin
    rst = 1'b0;
    sin_tab = '{0, 511, 0, -511};
    cos_tab = '{511, 0, -511, 0};

    // First symbol latency from PRBS, then mixer output with fcw=0.
    do_reset();
    bus.en = 1'b1;
    push_prbs();
    wait_strobe(40, n);
    chk("first_strobe_latency", n, 17);
    chk("mod_valid_at_strobe", bus.mod_valid, 0);
    step();
    chk("mod_valid_after", bus.mod_valid, 1);
    chk("mod_out_prbs", bus.mod_out, -1533);

    // External stream 1,0,1,1 with cycle-exact ext_ready.
    do_reset();
    bus.src_sel   = 1'b1;
    bus.ext_valid = 1'b1;
    bus.en        = 1'b1;
    push_word(4'b1011);
    for (int c = 0; c < 16; c++) begin
      bus.ext_bit = (c < 4 || c >= 8) ? 1'b1 : 1'b0;
      #1;
      ready_mask[c] = bus.ext_ready;
      step();
    end
    chk("ext_ready_pattern", ready_mask, 16'h8888);
    wait_strobe(8, n);
    chk("ext_strobe_latency", n, 1);
    chk("underrun_clean", bus.underrun, 0);

    // Missing bit inserted as zero; underrun sticky across a later good symbol.
    do_reset();
    bus.src_sel = 1'b1;
    bus.en      = 1'b1;
    push_word(4'b1011);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    wait_strobe(8, n);
    chk("underrun_set", bus.underrun, 1);
    push_word(4'b0110);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    wait_strobe(8, n);
    chk("underrun_sticky", bus.underrun, 1);

    // fcw=0: constant carrier, I=+3 Q=+1 gives 3*511.
    do_reset();
    bus.src_sel = 1'b1;
    bus.en      = 1'b1;
    push_word(4'b1011);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    wait_strobe(8, n);
    for (int j = 0; j < 3; j++) begin
      step();
      chk("dc_sin", bus.sin_out, 0);
      chk("dc_cos", bus.cos_out, 511);
      chk("dc_mod", bus.mod_out, 1533);
      chk("dc_mod_valid", bus.mod_valid, 1);
    end

    // Quarter-rate carrier.
    do_reset();
    bus.fcw = 16'd16384;
    bus.en  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("quarter_sin", bus.sin_out, sin_tab[(k - 1) % 4]);
      chk("quarter_cos", bus.cos_out, cos_tab[(k - 1) % 4]);
    end

    // Freeze mid-symbol for 5 cycles, then resume.
    do_reset();
    bus.fcw = 16'd1000;
    bus.en  = 1'b1;
    push_prbs();
    s1 = last_sym;
    push_prbs();
    for (int j = 0; j < 24; j++) step();
    bus.en = 1'b0;
    #1;
    chk("freeze_ext_ready", bus.ext_ready, 0);
    chk("freeze_mod_valid_now", bus.mod_valid, 0);
    for (int j = 0; j < 5; j++) begin
      step();
      chk("freeze_sin", bus.sin_out, sinm(23 * 1000));
      chk("freeze_cos", bus.cos_out, cosm(23 * 1000));
      chk("freeze_mod", bus.mod_out, s1.i * cosm(22 * 1000) - s1.q * sinm(22 * 1000));
      chk("freeze_mod_valid", bus.mod_valid, 0);
      chk("freeze_strobe", bus.sym_strobe, 0);
    end
    bus.en = 1'b1;
    wait_strobe(20, n);
    chk("resume_strobe_latency", n, 9);
    chk("resume_sin", bus.sin_out, sinm(32 * 1000));

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
